slave_out_port: RTL

Slave-side serial transmit port for the single-wire data bus. It takes a burst of words from the slave core and serialises each word LSB-first onto `tx_data` under an `s_valid`/`m_ready` handshake. It is the transmitting end of the master's serial receive port and sits between the slave core and the bus. A one-word prefetch buffer lets the core supply the next word while the current word shifts out.

---
 rtl/slave_out_port.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/slave_out_port.sv
// slave_out_port
//   Slave-side serial transmit port. Takes a burst of words from the slave
//   core and shifts each word out LSB-first on tx_data after a
//   s_valid/m_ready handshake. A one-word prefetch buffer lets the core hand
//   over the next word while the current one is still shifting.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            burst request from the core, honoured only in IDLE
//   burst_len        number of words in the burst, sampled with start
//   core_data/valid  next word from the core
//   core_ready       port accepts core_data this cycle (combinational)
//   m_ready          master ready to receive a word
//   s_valid          registered, a word is offered to the master
//   tx_data          registered serial data
//   busy             registered, high whenever the port is not IDLE
//   tx_done          registered, one-cycle pulse at end of burst
module slave_out_port #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned BURST_SIZE = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BURST_SIZE-1:0] burst_len,
    input  logic [WORD_SIZE-1:0]  core_data,
    input  logic                  core_valid,
    output logic                  core_ready,
    input  logic                  m_ready,
    output logic                  s_valid,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    // Value of bit_cnt on the edge that puts the final bit on the line.
    localparam logic [CW-1:0] PEN_BIT = CW'(WORD_SIZE - 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_OFFER = 2'd2;
    localparam logic [1:0] ST_SHIFT = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WORD_SIZE-1:0]  shift_q, shift_d;
    logic [WORD_SIZE-1:0]  buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BURST_SIZE-1:0] words_left_q, words_left_d;
    logic                  s_valid_q, s_valid_d;
    logic                  tx_data_q, tx_data_d;
    logic                  busy_q;
    logic                  tx_done_q, tx_done_d;
    logic                  core_accept;

    // words_left already counts the word currently shifting, so a nonzero
    // value means another word is still owed by the core.
    assign core_ready  = (state_q == ST_LOAD) ||
                         ((state_q == ST_SHIFT) && !buf_full_q && (words_left_q != '0));
    assign core_accept = core_ready && core_valid;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
        s_valid_d    = s_valid_q;
        tx_data_d    = 1'b0;
        tx_done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        words_left_d = burst_len;
                        state_d      = ST_LOAD;
                    end else begin
                        tx_done_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (core_valid) begin
                    shift_d   = core_data;
                    s_valid_d = 1'b1;
                    state_d   = ST_OFFER;
                end
            end

            ST_OFFER: begin
                if (m_ready) begin
                    s_valid_d = 1'b0;
                    tx_data_d = shift_q[0];
                    bit_cnt_d = '0;
                    if (words_left_q != '0) begin
                        words_left_d = words_left_q - BURST_SIZE'(1);
                    end
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                tx_data_d = shift_q[bit_cnt_q + CW'(1)];
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (core_accept) begin
                    buf_d      = core_data;
                    buf_full_d = 1'b1;
                end
                // End-of-word is decided on the edge that drives the last bit,
                // so the last bit still gets its full cycle while the next
                // offer (or tx_done) is already raised; handshakes can then
                // follow each other exactly WORD_SIZE edges apart.
                if (bit_cnt_q == PEN_BIT) begin
                    if (words_left_q == '0) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                    end else if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        s_valid_d  = 1'b1;
                        state_d    = ST_OFFER;
                    end else if (core_accept) begin
                        shift_d    = core_data;
                        buf_full_d = 1'b0;
                        s_valid_d  = 1'b1;
                        state_d    = ST_OFFER;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            s_valid_q    <= 1'b0;
            tx_data_q    <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            s_valid_q    <= s_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= (state_d != ST_IDLE);
            tx_done_q    <= tx_done_d;
        end
    end

    assign s_valid = s_valid_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule
